// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction-fetch and data load/store requesters.
// Data has fixed priority; a starvation counter forces an instruction grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               d_win;
    logic               i_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        d_win     = 1'b0;
        i_win     = 1'b0;
        i_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                d_win = d_req && !(i_req && (starve_q >= CNT_W'(STARVE_LIMIT)));
                i_win = !d_win && i_req;
                if (d_win) begin
                    d_gnt     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    // Writes complete in the grant cycle; only reads occupy the port.
                    if (!d_we) begin
                        state_d = ST_WAIT;
                        owner_d = OWN_D;
                        lat_d   = CNT_W'(MEM_LATENCY);
                    end
                end else if (i_win) begin
                    i_gnt    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = i_addr;
                    state_d  = ST_WAIT;
                    owner_d  = OWN_I;
                    lat_d    = CNT_W'(MEM_LATENCY);
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - CNT_W'(1);
                if (lat_q == CNT_W'(1)) begin
                    if (owner_q == OWN_I) begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                    end else if (owner_q == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // Count data wins that an instruction request had to sit through.
        if (!i_req || i_gnt) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != '1)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (reset) begin
            i_gnt     = 1'b0;
            i_rvalid  = 1'b0;
            i_rdata   = '0;
            d_gnt     = 1'b0;
            d_rvalid  = 1'b0;
            d_rdata   = '0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at MEM_LATENCY=1 and one at 3, sharing stimulus;
// the idle instance is held in reset while the other is exercised.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic        sel = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata;
    logic [31:0] rd_addr = '0;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_req, a_mem_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_req, b_mem_we;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic        m_i_gnt, m_i_rvalid, m_d_gnt, m_d_rvalid, m_mem_req, m_mem_we;
    logic [31:0] m_i_rdata, m_d_rdata, m_mem_addr, m_mem_wdata;
    logic [133:0] a_out, b_out;
    logic        act_rst;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h2402_0005 ^ ((a - 32'h40) << 4);
    endfunction

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset(reset_a),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset_b),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign a_out = {a_i_gnt, a_i_rvalid, a_i_rdata, a_d_gnt, a_d_rvalid, a_d_rdata,
                    a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata};
    assign b_out = {b_i_gnt, b_i_rvalid, b_i_rdata, b_d_gnt, b_d_rvalid, b_d_rdata,
                    b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata};
    assign {m_i_gnt, m_i_rvalid, m_i_rdata, m_d_gnt, m_d_rvalid, m_d_rdata,
            m_mem_req, m_mem_we, m_mem_addr, m_mem_wdata} = sel ? b_out : a_out;
    assign act_rst = sel ? reset_b : reset_a;

    // Memory model: read data for the last read address presented, held until the next read.
    always @(posedge clk) if (m_mem_req && !m_mem_we) rd_addr <= m_mem_addr;
    assign mem_rdata = mem_fn(rd_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor: rvalid timing/port/data, rdata gating, outputs zero under reset.
    always @(negedge clk) begin
        logic        exp_iv, exp_dv;
        logic [31:0] exp_data;
        sb_t         e;
        if (reset_a) chk("rst_a_outputs_zero", 64'(|a_out), 64'd0);
        if (reset_b) chk("rst_b_outputs_zero", 64'(|b_out), 64'd0);
        if (!act_rst) begin
            exp_iv = 1'b0;
            exp_dv = 1'b0;
            exp_data = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_iv = !e.is_d;
                exp_dv = e.is_d;
                exp_data = e.data;
            end
            chk("i_rvalid", 64'(m_i_rvalid), 64'(exp_iv));
            chk("i_rdata", 64'(m_i_rdata), exp_iv ? 64'(exp_data) : 64'd0);
            chk("d_rvalid", 64'(m_d_rvalid), 64'(exp_dv));
            chk("d_rdata", 64'(m_d_rdata), exp_dv ? 64'(exp_data) : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic is_d, input logic [31:0] addr, input int lat);
        sb_t e;
        e.is_d = is_d;
        e.data = mem_fn(addr);
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic chk_grant(input string tag, input logic ig, input logic dg, input logic mr,
                             input logic mw, input logic [31:0] ma, input logic [31:0] md);
        chk({tag, "_i_gnt"}, 64'(m_i_gnt), 64'(ig));
        chk({tag, "_d_gnt"}, 64'(m_d_gnt), 64'(dg));
        chk({tag, "_mem_req"}, 64'(m_mem_req), 64'(mr));
        chk({tag, "_mem_we"}, 64'(m_mem_we), 64'(mw));
        chk({tag, "_mem_addr"}, 64'(m_mem_addr), 64'(ma));
        chk({tag, "_mem_wdata"}, 64'(m_mem_wdata), 64'(md));
    endtask

    initial begin
        step(); step();
        reset_a = 1'b0;
        // Idle bus, no requests
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_grant("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end

        // Instruction read, latency 1
        i_req = 1'b1; i_addr = 32'h40;
        expect_rd(1'b0, 32'h40, 1);
        @(negedge clk);
        chk_grant("t1_grant", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        i_req = 1'b0;
        @(negedge clk);
        chk_grant("t1_wait", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Simultaneous requests: data wins, instruction follows
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h5555_AAAA;
        expect_rd(1'b1, 32'h100, 1);
        @(negedge clk);
        chk_grant("t2_dgrant", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h5555_AAAA);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk_grant("t2_hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        expect_rd(1'b0, 32'h80, 1);
        @(negedge clk);
        chk_grant("t2_igrant", 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
        step();
        i_req = 1'b0;
        step();

        // Starvation override after four data writes
        i_req = 1'b1; i_addr = 32'hC0;
        d_req = 1'b1; d_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_addr = 32'h200 + 32'(4 * k);
            d_wdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            chk_grant("t3_write", 1'b0, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            step();
        end
        d_addr = 32'h210; d_wdata = 32'hA000_0004;
        expect_rd(1'b0, 32'hC0, 1);
        @(negedge clk);
        chk_grant("t3_starve", 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h0);
        step();
        i_addr = 32'hC4;
        @(negedge clk);
        chk_grant("t3_wait", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk_grant("t3_cleared", 1'b0, 1'b1, 1'b1, 1'b1, 32'h210, 32'hA000_0004);
        step();
        d_req = 1'b0; d_we = 1'b0;
        expect_rd(1'b0, 32'hC4, 1);
        @(negedge clk);
        chk_grant("t3_ifollow", 1'b1, 1'b0, 1'b1, 1'b0, 32'hC4, 32'h0);
        step();
        i_req = 1'b0;
        step(); step();

        // Switch to latency-3 instance
        reset_a = 1'b1; reset_b = 1'b0; sel = 1'b1;
        step();

        // Data read with latency 3, pending instruction waits
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
        i_req = 1'b1; i_addr = 32'h44;
        expect_rd(1'b1, 32'h300, 3);
        @(negedge clk);
        chk_grant("t4_dgrant", 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        step();
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_grant("t4_wait", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        expect_rd(1'b0, 32'h44, 3);
        @(negedge clk);
        chk_grant("t4_igrant", 1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
        step();
        i_req = 1'b0;
        step(); step(); step(); step();

        // Reset during an in-flight read abandons it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h308;
        @(negedge clk);
        chk_grant("t5_dgrant", 1'b0, 1'b1, 1'b1, 1'b0, 32'h308, 32'h0);
        step();
        d_req = 1'b0; reset_b = 1'b1;
        step();
        step();
        reset_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_grant("t5_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        i_req = 1'b1; i_addr = 32'h48;
        expect_rd(1'b0, 32'h48, 3);
        @(negedge clk);
        chk_grant("t5_idle_grant", 1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0);
        step();
        i_req = 1'b0;
        step(); step(); step(); step();

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch requester and its data-load/store requester. Sits between the processor core and the memory model or SRAM. The block does the following:
- Arbitrates with fixed data priority plus an instruction anti-starvation override.
- Sequences single-outstanding reads with a fixed memory latency.
- Returns read data and a valid strobe to the requester that owns the access.

Parameters:
MEM_LATENCY, 1, cycles from mem_req (read) to mem_rdata valid; legal range 1..15.
STARVE_LIMIT, 4, consecutive data grants while i_req is pending before the instruction port is forced to win; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
i_req  in  1  instruction read request; held with i_addr until i_gnt.
i_addr  in  32  instruction word address.
i_gnt  out  1  instruction request accepted this cycle.
i_rvalid  out  1  i_rdata valid, one-cycle pulse.
i_rdata  out  32  instruction read data.
d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_gnt.
d_we  in  1  1 = write, 0 = read.
d_addr  in  32  data address.
d_wdata  in  32  store data.
d_gnt  out  1  data request accepted this cycle.
d_rvalid  out  1  d_rdata valid, one-cycle pulse; reads only.
d_rdata  out  32  data read data.
mem_req  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  32  memory address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after a read mem_req.

Behaviour:
- Reset:
  - Synchronous, active-high, on clk.
  - Next state is IDLE; latency counter = 0; owner = none; starvation counter = 0.
  - While reset is high, all outputs are forced to 0.
- State machine: IDLE, WAIT.
- IDLE, arbitration (combinational, same cycle):
  - Winner is data if d_req=1 and not (i_req=1 and starve_cnt >= STARVE_LIMIT).
  - Otherwise the winner is instruction if i_req=1.
  - Otherwise there is no winner.
- IDLE, outputs with a winner:
  - Winner's gnt=1 and mem_req=1.
  - mem_addr and mem_wdata come from the winner.
  - mem_we = d_we if data wins; 0 if instruction wins.
- IDLE, outputs with no winner: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE, transitions:
  - Granted read: load latency counter with MEM_LATENCY, register the owner, go to WAIT.
  - Granted write: stay in IDLE. The next request can be granted the following cycle (1 write per cycle).
- WAIT:
  - No grants; mem_req=0.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, the owner's rvalid=1 and its rdata = mem_rdata (combinational pass-through). The FSM returns to IDLE on the next edge.
  - Read throughput is therefore 1 per MEM_LATENCY+1 cycles.
- rdata gating: i_rdata and d_rdata are 0 whenever their rvalid=0.
- Starvation counter:
  - Increments (saturating at 15) on each data grant while i_req=1.
  - Clears on any instruction grant, or in any cycle where i_req=0.
- Simultaneous events: a request arriving while in WAIT is held off (gnt=0) and arbitrated in the first IDLE cycle. A request presented in the rvalid cycle is not granted until the next cycle.
- Protocol violation: a requester deasserting req before gnt is legal; it simply loses that cycle. No other state changes.
- Reset mid-read: the in-flight read is abandoned. No rvalid is emitted, and a late mem_rdata is ignored.
- Address bits are forwarded unchanged; alignment is the requester's responsibility.
- Writes never produce rvalid.

Test Plan:
1. Reset, then i_req=1, i_addr=0x0000_0040, MEM_LATENCY=1 -> i_gnt=1 and mem_req=1, mem_addr=0x40, mem_we=0 in cycle T. In T+1, mem_rdata=0x2402_0005 -> i_rvalid=1, i_rdata=0x2402_0005. IDLE at T+2.
2. i_req=1 and d_req=1 (d_we=0, d_addr=0x100) in the same cycle -> d_gnt=1, i_gnt=0. d_rvalid one cycle later. i_gnt granted in the first IDLE cycle after that.
3. d_req held high with writes (d_we=1, d_addr 0x200,0x204,...), i_req=1, STARVE_LIMIT=4 -> four consecutive write grants, then i_gnt=1 on the 5th arbitration; starve_cnt clears.
4. MEM_LATENCY=3, data read of 0x300 granted at T -> no grants at T+1..T+3. d_rvalid=1 only at T+3, d_rdata=mem_rdata. A pending i_req is granted at T+4.
5. Reset asserted at T+1 during a MEM_LATENCY=3 read -> no rvalid at any later cycle; all outputs 0 during reset; IDLE afterwards.
6. Idle bus with no requests -> mem_req=0, mem_addr=0, mem_wdata=0, gnts=0, rvalids=0 every cycle.
